// File: rtl/result_collector.sv
// Collects signed row results from the row multiplier into a small register file,
// tracks the argmax, and serves results plus a status word on a registered read port.
module result_collector #(
    parameter int NUM_ROWS = 10,
    parameter int RES_W    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    row_valid,
    input  logic signed [RES_W-1:0] row_result,
    input  logic                    rd_en,
    input  logic [3:0]              rd_addr,
    output logic [RES_W:0]          rd_data,
    output logic                    rd_valid,
    output logic                    done_calc,
    output logic                    busy,
    output logic [3:0]              best_index,
    output logic                    err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    localparam logic [3:0]             LAST_ROW   = 4'(NUM_ROWS - 1);
    localparam logic [3:0]             ROW_LIMIT  = 4'(NUM_ROWS);
    localparam logic [3:0]             STATUS_ADR = 4'd15;
    localparam logic signed [RES_W-1:0] MOST_NEG  = {1'b1, {(RES_W-1){1'b0}}};

    state_t                    r_state;
    state_t                    w_state_next;
    logic                      w_capture;
    logic                      w_stray;
    logic                      w_last;
    logic [3:0]                r_count;
    logic signed [RES_W-1:0]   r_buf [NUM_ROWS];
    logic [NUM_ROWS-1:0]       r_vld;
    logic signed [RES_W-1:0]   r_best_value;
    logic [3:0]                r_best_index;
    logic                      r_err;
    logic                      r_done_calc;
    logic [RES_W:0]            r_rd_data;
    logic                      r_rd_valid;
    logic [RES_W:0]            w_rd_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: every sequential block uses <= so all registers see pre-edge values.
            r_state <= w_state_next;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through this block can infer a latch.
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_stray      = 1'b0;
        if (clear) begin
            w_state_next = S_COLLECT;
        end else begin
            case (r_state)
                S_COLLECT: begin
                    if (row_valid) begin
                        w_capture = 1'b1;
                        if (r_count == LAST_ROW) w_state_next = S_DONE;
                    end
                end
                default: w_stray = row_valid;
            endcase
        end
    end

    assign w_last = w_capture && (r_count == LAST_ROW);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count      <= '0;
            r_vld        <= '0;
            r_best_value <= MOST_NEG;
            r_best_index <= '0;
            r_err        <= 1'b0;
            r_done_calc  <= 1'b0;
        end else begin
            r_done_calc <= w_last;
            if (clear) begin
                r_count      <= '0;
                r_vld        <= '0;
                r_best_value <= MOST_NEG;
                r_best_index <= '0;
                r_err        <= 1'b0;
            end else begin
                if (w_capture) begin
                    r_vld[r_count] <= 1'b1;
                    // Strict compare keeps the lower index on ties.
                    if (row_result > r_best_value) begin
                        r_best_value <= row_result;
                        r_best_index <= r_count;
                    end
                    if (!w_last) r_count <= r_count + 4'd1;
                end
                if (w_stray) r_err <= 1'b1;
            end
        end
    end

    // NOTE: the result storage has no reset; the per-entry valid flags say whether it is meaningful.
    always_ff @(posedge clk) begin
        if (w_capture) r_buf[r_count] <= row_result;
    end

    always_comb begin
        w_rd_word = '0;
        if (rd_addr < ROW_LIMIT) begin
            w_rd_word = {r_vld[rd_addr], r_buf[rd_addr]};
        end else if (rd_addr == STATUS_ADR) begin
            w_rd_word[RES_W] = (r_state == S_DONE);
            w_rd_word[4]     = r_err;
            w_rd_word[3:0]   = r_best_index;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) r_rd_data <= w_rd_word;
        end
    end

    assign rd_data    = r_rd_data;
    assign rd_valid   = r_rd_valid;
    assign done_calc  = r_done_calc;
    assign busy       = (r_state == S_COLLECT);
    assign best_index = r_best_index;
    assign err        = r_err;

endmodule
